// File: rtl/branch_predict_ctl.sv
// Purpose : BTB + 2-bit counter branch predictor with EX-stage resolve, redirect and flush.
// Latency : prediction and redirect/flush are combinational; BTB/counter updates visible next cycle.
// Backpressure: enable=0 stalls all state and forces redirect/flush low; no ready handshake.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   enable               pipeline advance; 0 freezes all state
//   if_pc -> pred_taken, pred_target        fetch-stage lookup
//   ex_valid, ex_pc, ex_is_cond, ex_taken, ex_target,
//   ex_pred_taken, ex_pred_target           EX-stage resolution inputs
//   redirect, redirect_pc, flush            PC correction and squash
//   branch_cnt, mispred_cnt                 saturating statistics
module branch_predict_ctl #(
    parameter int ADDR_W      = 8,
    parameter int BTB_DEPTH   = 8,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_is_cond,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W;
    // Counter only needs to hold FLUSH_DEPTH-1; keep at least one bit.
    localparam int FC_W  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } btb_entry_t;

    btb_entry_t btb [BTB_DEPTH];
    logic [FC_W-1:0] flush_cnt;

    // Fetch-side lookup (reads pre-update contents on a same-index collision)
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    btb_entry_t       if_entry;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W-1:0];
    assign if_tag      = if_pc[ADDR_W-1:IDX_W];
    assign if_entry    = btb[if_idx];
    assign if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    assign pred_taken  = if_hit && if_entry.ctr[1];
    assign pred_target = if_hit ? if_entry.target : if_pc + ADDR_W'(1);

    // Resolution side
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    btb_entry_t       ex_entry;
    logic             ex_hit;
    logic             acc;
    logic             mispredict;

    assign ex_idx   = ex_pc[IDX_W-1:0];
    assign ex_tag   = ex_pc[ADDR_W-1:IDX_W];
    assign ex_entry = btb[ex_idx];
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

    // Resolutions arriving inside a flush window belong to squashed slots.
    assign acc        = enable && ex_valid && (flush_cnt == '0);
    assign mispredict = acc && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_target != ex_pred_target)));

    assign redirect    = mispredict;
    assign redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(1);
    assign flush       = enable && (mispredict || (flush_cnt != '0));

    // Next BTB entry at ex_pc's index
    btb_entry_t upd_entry;
    logic       upd_we;

    always_comb begin
        upd_entry = ex_entry;
        upd_we    = 1'b0;
        if (acc) begin
            if (ex_hit) begin
                upd_we = 1'b1;
                if (ex_is_cond) begin
                    if (ex_taken) begin
                        if (ex_entry.ctr != 2'b11) upd_entry.ctr = ex_entry.ctr + 2'b01;
                        upd_entry.target = ex_target;
                    end else if (ex_entry.ctr != 2'b00) begin
                        upd_entry.ctr = ex_entry.ctr - 2'b01;
                    end
                end else begin
                    upd_entry.ctr    = 2'b11;
                    upd_entry.target = ex_target;
                end
            end else if (ex_taken) begin
                // Allocate; conditional branches start weakly taken, jumps strongly.
                upd_we           = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = ex_tag;
                upd_entry.target = ex_target;
                upd_entry.ctr    = ex_is_cond ? 2'b10 : 2'b11;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) btb[i] <= '0;
            flush_cnt   <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (enable) begin
            // mispredict implies flush_cnt==0, so the two branches never collide.
            if (mispredict)
                flush_cnt <= FC_W'(FLUSH_DEPTH - 1);
            else if (flush_cnt != '0)
                flush_cnt <= flush_cnt - FC_W'(1);

            if (acc) begin
                if (~&branch_cnt) branch_cnt <= branch_cnt + CNT_W'(1);
                if (mispredict && ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
            end

            if (upd_we) btb[ex_idx] <= upd_entry;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctl.sv
module tb_branch_predict_ctl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int FDEPTH = 3;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset, enable;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid, ex_is_cond, ex_taken, ex_pred_taken;
    logic [ADDR_W-1:0] ex_pc, ex_target, ex_pred_target;
    logic              redirect, flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  branch_cnt, mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per BTB slot, flush window as "cycles left".
    int m_valid [DEPTH];
    int m_tag   [DEPTH];
    int m_tgt   [DEPTH];
    int m_ctr   [DEPTH];
    int m_flush_left;
    int m_bcnt, m_mcnt;

    branch_predict_ctl #(
        .ADDR_W(ADDR_W), .BTB_DEPTH(DEPTH), .FLUSH_DEPTH(FDEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_cond(ex_is_cond),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_flush_left = 0; m_bcnt = 0; m_mcnt = 0;
    endtask

    // Check every output against the model for the current inputs, then clock
    // the DUT and advance the model with the same inputs.
    task automatic tick();
        int  ii, ei, ipc, epc, etg;
        bit  ihit, ehit, acc, mis;
        #1;
        ipc  = int'(if_pc);
        epc  = int'(ex_pc);
        etg  = int'(ex_target);
        ii   = ipc % DEPTH;
        ihit = (m_valid[ii] != 0) && (m_tag[ii] == ipc / DEPTH);
        check_eq("pred_taken", pred_taken, ihit && (m_ctr[ii] >= 2));
        check_eq("pred_target", pred_target, ihit ? m_tgt[ii] : (ipc + 1) % 256);
        acc = enable && ex_valid && (m_flush_left == 0);
        mis = acc && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target)));
        check_eq("redirect", redirect, mis);
        check_eq("redirect_pc", redirect_pc, ex_taken ? etg : (epc + 1) % 256);
        check_eq("flush", flush, enable && (mis || m_flush_left > 0));
        check_eq("branch_cnt", branch_cnt, m_bcnt);
        check_eq("mispred_cnt", mispred_cnt, m_mcnt);

        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (enable) begin
            if (mis) m_flush_left = FDEPTH - 1;
            else if (m_flush_left > 0) m_flush_left--;
            if (acc) begin
                if (m_bcnt < CNT_MAX) m_bcnt++;
                if (mis && m_mcnt < CNT_MAX) m_mcnt++;
                ei   = epc % DEPTH;
                ehit = (m_valid[ei] != 0) && (m_tag[ei] == epc / DEPTH);
                if (ehit && ex_is_cond) begin
                    if (ex_taken) begin
                        m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
                        m_tgt[ei] = etg;
                    end else begin
                        m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
                    end
                end else if (ehit) begin
                    m_ctr[ei] = 3;
                    m_tgt[ei] = etg;
                end else if (ex_taken) begin
                    m_valid[ei] = 1;
                    m_tag[ei]   = epc / DEPTH;
                    m_tgt[ei]   = etg;
                    m_ctr[ei]   = ex_is_cond ? 2 : 3;
                end
            end
        end
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [7:0] pc, input logic cond,
                          input logic tk, input logic [7:0] tgt,
                          input logic ptk, input logic [7:0] ptgt);
        ex_valid = v; ex_pc = pc; ex_is_cond = cond; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int  pi, r;
        bit  phit;
        reset = 1'b1; enable = 1'b1; if_pc = 8'h0b;
        set_ex(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: reset state
        #1;
        check_eq("t1_pred_taken", pred_taken, 1'b0);
        check_eq("t1_pred_target", pred_target, 8'h0c);
        check_eq("t1_branch_cnt", branch_cnt, 16'd0);
        check_eq("t1_flush", flush, 1'b0);
        tick();

        // 2: cold conditional taken branch
        set_ex(1'b1, 8'h0b, 1'b1, 1'b1, 8'h2a, 1'b0, 8'h0c);
        #1;
        check_eq("t2_redirect", redirect, 1'b1);
        check_eq("t2_redirect_pc", redirect_pc, 8'h2a);
        tick();
        idle(2);
        #1;
        check_eq("t2_flush_done", flush, 1'b0);
        check_eq("t2_mispred", mispred_cnt, 16'd1);
        check_eq("t2_pred_taken", pred_taken, 1'b1);
        check_eq("t2_pred_target", pred_target, 8'h2a);
        tick();

        // 3: correct prediction, then two not-taken resolutions
        set_ex(1'b1, 8'h0b, 1'b1, 1'b1, 8'h2a, 1'b1, 8'h2a);
        #1;
        check_eq("t3_redirect", redirect, 1'b0);
        check_eq("t3_flush", flush, 1'b0);
        tick();
        set_ex(1'b1, 8'h0b, 1'b1, 1'b0, 8'h2a, 1'b1, 8'h2a);
        #1;
        check_eq("t3_bcnt", branch_cnt, 16'd2);
        check_eq("t3_mcnt", mispred_cnt, 16'd1);
        check_eq("t3_nt_redirect_pc", redirect_pc, 8'h0c);
        check_eq("t3_nt_redirect", redirect, 1'b1);
        tick();
        idle(2);
        #1;
        check_eq("t3_ctr10_taken", pred_taken, 1'b1);
        set_ex(1'b1, 8'h0b, 1'b1, 1'b0, 8'h2a, 1'b1, 8'h2a);
        tick();
        idle(2);
        #1;
        check_eq("t3_ctr01_taken", pred_taken, 1'b0);

        // 4: aliasing at index 3
        if_pc = 8'h13;
        #1;
        check_eq("t4_alias_miss", pred_taken, 1'b0);
        check_eq("t4_alias_tgt", pred_target, 8'h14);
        set_ex(1'b1, 8'h13, 1'b0, 1'b1, 8'h0f, 1'b0, 8'h14);
        tick();
        idle(2);
        if_pc = 8'h0b;
        #1;
        check_eq("t4_old_miss", pred_target, 8'h0c);
        if_pc = 8'h13;
        #1;
        check_eq("t4_new_hit", pred_target, 8'h0f);
        tick();

        // 5: resolutions inside the flush window are ignored
        set_ex(1'b1, 8'h05, 1'b1, 1'b1, 8'h30, 1'b0, 8'h06);
        tick();
        set_ex(1'b1, 8'h21, 1'b1, 1'b1, 8'h40, 1'b0, 8'h22);
        #1;
        check_eq("t5_ignored_redirect", redirect, 1'b0);
        tick();
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("t5_bcnt", branch_cnt, 16'd6);
        check_eq("t5_mcnt", mispred_cnt, 16'd5);
        // reset during flush cycle 2
        set_ex(1'b1, 8'h05, 1'b1, 1'b0, 8'h30, 1'b1, 8'h30);
        tick();
        ex_valid = 1'b0; reset = 1'b1;
        #1;
        check_eq("t5_flush_pre_reset", flush, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        check_eq("t5_flush_after_reset", flush, 1'b0);
        check_eq("t5_bcnt_reset", branch_cnt, 16'd0);
        tick();

        // 6: stall, same-index collision, PC wrap
        enable = 1'b0; if_pc = 8'h0b;
        set_ex(1'b1, 8'h0b, 1'b1, 1'b1, 8'h2a, 1'b0, 8'h0c);
        #1;
        check_eq("t6_stall_redirect", redirect, 1'b0);
        check_eq("t6_stall_flush", flush, 1'b0);
        tick();
        enable = 1'b1;
        #1;
        check_eq("t6_stall_no_update", pred_taken, 1'b0);
        check_eq("t6_collide_old", pred_target, 8'h0c);
        tick();
        ex_valid = 1'b0;
        #1;
        check_eq("t6_collide_new", pred_target, 8'h2a);
        idle(2);
        set_ex(1'b1, 8'hff, 1'b1, 1'b0, 8'h10, 1'b1, 8'h10);
        #1;
        check_eq("t6_wrap_pc", redirect_pc, 8'h00);
        check_eq("t6_wrap_redirect", redirect, 1'b1);
        tick();
        idle(2);

        // Randomized traffic over a small PC range so hits and aliases are common.
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if_pc  = 8'($urandom_range(0, 39));
            ex_valid   = $urandom_range(0, 1) == 1;
            ex_pc      = (c % 50 == 0) ? 8'hff : 8'($urandom_range(0, 39));
            ex_is_cond = $urandom_range(0, 2) != 0;
            ex_taken   = ex_is_cond ? ($urandom_range(0, 1) == 1) : 1'b1;
            ex_target  = 8'($urandom_range(0, 63));
            pi   = int'(ex_pc) % DEPTH;
            phit = (m_valid[pi] != 0) && (m_tag[pi] == int'(ex_pc) / DEPTH);
            r    = $urandom_range(0, 3);
            if (r != 0) begin
                ex_pred_taken  = phit && (m_ctr[pi] >= 2);
                ex_pred_target = phit ? 8'(m_tgt[pi]) : ex_pc + 8'd1;
            end else begin
                ex_pred_taken  = $urandom_range(0, 1) == 1;
                ex_pred_target = 8'($urandom_range(0, 63));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
